// File: rtl/peg_row_sequencer_if.sv
// ----------------------------------------------------------------------------
// peg_row_sequencer_if
//   Groups the request side (from the game FSM) and the output side (to the
//   4x4 peg drawer and the VGA adapter) of peg_row_sequencer.
//
//   Request  : start, erase, row[3:0], guess[11:0], exact_cnt[2:0],
//              partial_cnt[2:0]
//   Drawer   : x_out[7:0], y_out[6:0], load, draw, rest_draw
//   VGA      : colour[2:0], plot
//   Status   : busy, done
//
//   master : the requester (game FSM or testbench)
//   slave  : the sequencer itself
// ----------------------------------------------------------------------------
interface peg_row_sequencer_if;
    logic        start;
    logic        erase;
    logic [3:0]  row;
    logic [11:0] guess;
    logic [2:0]  exact_cnt;
    logic [2:0]  partial_cnt;

    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic        load;
    logic        draw;
    logic        rest_draw;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, erase, row, guess, exact_cnt, partial_cnt,
        input  x_out, y_out, load, draw, rest_draw, colour, plot, busy, done
    );

    modport slave (
        input  start, erase, row, guess, exact_cnt, partial_cnt,
        output x_out, y_out, load, draw, rest_draw, colour, plot, busy, done
    );
endinterface

// File: rtl/peg_row_sequencer.sv
// ----------------------------------------------------------------------------
// peg_row_sequencer
//   Renders one board row on request: four guess pegs followed by four
//   feedback pegs. For every peg it loads the top-left pixel into the 4x4
//   drawer (one LOAD cycle), then holds draw/plot for DRAW_CYCLES cycles
//   while driving the peg colour. A row takes 8*(1+DRAW_CYCLES) cycles plus
//   a one-cycle DONE pulse.
//
//   Ports
//     clk     : system clock
//     resetn  : synchronous, active-low reset; aborts a row in progress
//     bus     : peg_row_sequencer_if.slave
//               in  start, erase, row, guess, exact_cnt, partial_cnt
//               out x_out, y_out, load, draw, rest_draw, colour, plot,
//                   busy, done
//
//   All outputs are registered: each state's output values are written on
//   the same edge that enters the state.
// ----------------------------------------------------------------------------
module peg_row_sequencer #(
    parameter int unsigned X_ORIGIN    = 8,
    parameter int unsigned Y_ORIGIN    = 4,
    parameter int unsigned PEG_PITCH   = 6,
    parameter int unsigned ROW_PITCH   = 8,
    parameter int unsigned FB_X_OFFSET = 32,
    parameter int unsigned FB_PITCH    = 5,
    parameter int unsigned MAX_ROWS    = 10,
    parameter int unsigned DRAW_CYCLES = 16,
    parameter logic [2:0]  COL_EXACT   = 3'b100,
    parameter logic [2:0]  COL_PARTIAL = 3'b111,
    parameter logic [2:0]  COL_BG      = 3'b000
) (
    input logic                clk,
    input logic                resetn,
    peg_row_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(DRAW_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_p;       // 0..3 guess pegs, 4..7 feedback pegs
    logic [4:0]  r_cnt;

    // Request snapshot taken when a row is accepted
    logic [3:0]  r_row;
    logic [11:0] r_guess;
    logic        r_erase;
    logic [2:0]  r_e;
    logic [2:0]  r_pc;

    // Registered outputs
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic        r_load;
    logic        r_draw;
    logic        r_rest;
    logic [2:0]  r_colour;
    logic        r_plot;
    logic        r_busy;
    logic        r_done;

    logic        w_row_ok;
    logic [2:0]  w_e;
    logic [2:0]  w_room;
    logic [2:0]  w_pc;

    // Counts are clamped so that E+P never exceeds the four feedback slots.
    assign w_row_ok = 32'(bus.row) < MAX_ROWS;
    assign w_e      = (bus.exact_cnt > 3'd4) ? 3'd4 : bus.exact_cnt;
    assign w_room   = 3'd4 - w_e;
    assign w_pc     = (bus.partial_cnt > w_room) ? w_room : bus.partial_cnt;

    // Coordinates are formed at 9 bits and truncated to the port widths.
    function automatic logic [7:0] peg_x(input logic [2:0] p);
        logic [8:0] x;
        if (!p[2])
            x = 9'(X_ORIGIN) + 9'(p) * 9'(PEG_PITCH);
        else
            x = 9'(X_ORIGIN) + 9'(FB_X_OFFSET) + 9'({1'b0, p[1:0]}) * 9'(FB_PITCH);
        return x[7:0];
    endfunction

    function automatic logic [6:0] peg_y(input logic [3:0] row);
        logic [8:0] y;
        y = 9'(Y_ORIGIN) + 9'(row) * 9'(ROW_PITCH);
        return y[6:0];
    endfunction

    // Feedback slot j shows E exact markers, then P partial markers, then
    // background.
    function automatic logic [2:0] peg_colour(
        input logic [2:0]  p,
        input logic        erase,
        input logic [11:0] guess,
        input logic [2:0]  e,
        input logic [2:0]  pc
    );
        logic [2:0] j;
        logic [2:0] c;
        j = {1'b0, p[1:0]};
        if (erase) begin
            c = COL_BG;
        end else if (!p[2]) begin
            case (p[1:0])
                2'd0:    c = guess[2:0];
                2'd1:    c = guess[5:3];
                2'd2:    c = guess[8:6];
                default: c = guess[11:9];
            endcase
        end else if (j < e) begin
            c = COL_EXACT;
        end else if (j < e + pc) begin
            c = COL_PARTIAL;
        end else begin
            c = COL_BG;
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_p      <= 3'd0;
            r_cnt    <= 5'd0;
            r_row    <= 4'd0;
            r_guess  <= 12'd0;
            r_erase  <= 1'b0;
            r_e      <= 3'd0;
            r_pc     <= 3'd0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_load   <= 1'b0;
            r_draw   <= 1'b0;
            r_rest   <= 1'b0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // Strobes default low; each branch raises what the next state needs.
            r_load   <= 1'b0;
            r_rest   <= 1'b0;
            r_draw   <= 1'b0;
            r_plot   <= 1'b0;
            r_colour <= 3'd0;
            r_done   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.start && w_row_ok) begin
                        r_row   <= bus.row;
                        r_guess <= bus.guess;
                        r_erase <= bus.erase;
                        r_e     <= w_e;
                        r_pc    <= w_pc;
                        r_p     <= 3'd0;
                        r_state <= S_LOAD;
                        r_load  <= 1'b1;
                        r_rest  <= 1'b1;
                        r_busy  <= 1'b1;
                        // Row comes straight from the port here; the snapshot
                        // only becomes visible next cycle.
                        r_x     <= peg_x(3'd0);
                        r_y     <= peg_y(bus.row);
                    end
                end

                S_LOAD: begin
                    r_state  <= S_DRAW;
                    r_cnt    <= 5'd0;
                    r_draw   <= 1'b1;
                    r_plot   <= 1'b1;
                    r_busy   <= 1'b1;
                    r_colour <= peg_colour(r_p, r_erase, r_guess, r_e, r_pc);
                end

                S_DRAW: begin
                    if (r_cnt == LAST_CNT) begin
                        if (r_p == 3'd7) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_p     <= r_p + 3'd1;
                            r_state <= S_LOAD;
                            r_load  <= 1'b1;
                            r_rest  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_x     <= peg_x(r_p + 3'd1);
                            r_y     <= peg_y(r_row);
                        end
                    end else begin
                        r_cnt    <= r_cnt + 5'd1;
                        r_draw   <= 1'b1;
                        r_plot   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_colour <= r_colour;
                    end
                end

                S_DONE: begin
                    // start is deliberately not looked at in this cycle
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x_out     = r_x;
    assign bus.y_out     = r_y;
    assign bus.load      = r_load;
    assign bus.draw      = r_draw;
    assign bus.rest_draw = r_rest;
    assign bus.colour    = r_colour;
    assign bus.plot      = r_plot;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_peg_row_sequencer.sv
// ----------------------------------------------------------------------------
// tb_peg_row_sequencer
//   Table of hand-computed rows, randomized rows checked against a
//   rule-level model, plus sequences for invalid row, start re-pulse and
//   reset mid-row. Observed outputs are packed as
//   {x(8), y(7), load, draw, rest_draw, colour(3), plot, busy, done}.
// ----------------------------------------------------------------------------
module tb_peg_row_sequencer;

    logic clk;
    logic resetn;

    peg_row_sequencer_if bus ();

    peg_row_sequencer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      row;
        logic [11:0]     guess;
        logic            erase;
        logic [2:0]      ex;
        logic [2:0]      pa;
        logic [7:0][7:0] x;
        logic [6:0]      y;
        logic [7:0][2:0] col;
    } vec_t;

    localparam logic [23:0] M_ALL  = 24'hFFFFFF;
    localparam logic [23:0] M_NOXY = 24'h0001FF;
    localparam int          ROW_CYC = 137;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [23:0] obs();
        return {bus.x_out, bus.y_out, bus.load, bus.draw, bus.rest_draw,
                bus.colour, bus.plot, bus.busy, bus.done};
    endfunction

    task automatic check(input string name, input int k, input logic [23:0] act,
                         input logic [23:0] exp, input logic [23:0] mask);
        n_cmp++;
        if ((act & mask) !== (exp & mask)) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h (mask %h)",
                     name, k, act & mask, exp & mask, mask);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model built directly from the placement / colouring rules.
    function automatic vec_t model(input logic [3:0] row, input logic [11:0] guess,
                                   input logic erase, input logic [2:0] ex,
                                   input logic [2:0] pa);
        vec_t v;
        int e, p, yy;
        logic [2:0] fb[$];
        v = '0;
        v.row = row; v.guess = guess; v.erase = erase; v.ex = ex; v.pa = pa;
        yy = 4 + int'(row) * 8;
        v.y = 7'(yy);
        e = (int'(ex) > 4) ? 4 : int'(ex);
        p = (int'(pa) > 4 - e) ? 4 - e : int'(pa);
        for (int i = 0; i < e; i++) fb.push_back(3'b100);
        for (int i = 0; i < p; i++) fb.push_back(3'b111);
        while (fb.size() < 4) fb.push_back(3'b000);
        for (int i = 0; i < 4; i++) begin
            v.x[i]     = 8'(8 + 6 * i);
            v.x[i + 4] = 8'(8 + 32 + 5 * i);
            v.col[i]     = erase ? 3'b000 : guess[3 * i +: 3];
            v.col[i + 4] = erase ? 3'b000 : fb[i];
        end
        return v;
    endfunction

    function automatic logic [23:0] expect_at(input vec_t v, input int k);
        int peg, ph;
        if (k == ROW_CYC) return 24'h000001;
        peg = (k - 1) / 17;
        ph  = (k - 1) % 17;
        if (ph == 0)
            return {v.x[peg], v.y, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0};
        return {v.x[peg], v.y, 1'b0, 1'b1, 1'b0, v.col[peg], 1'b1, 1'b1, 1'b0};
    endfunction

    // Runs one row starting at the next negedge. jitter scrambles request
    // inputs while busy; repulse fires a second start during peg 3;
    // cut_at > 0 asserts reset at that cycle and abandons the row.
    task automatic run_row(input string name, input vec_t v, input bit jitter,
                           input bit repulse, input int cut_at);
        int loads, draws, dones;
        loads = 0; draws = 0; dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.row = v.row; bus.guess = v.guess; bus.erase = v.erase;
        bus.exact_cnt = v.ex; bus.partial_cnt = v.pa;
        for (int k = 1; k <= ROW_CYC; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            check(name, k, obs(), expect_at(v, k), (k == ROW_CYC) ? M_NOXY : M_ALL);
            loads += int'(bus.load); draws += int'(bus.draw); dones += int'(bus.done);
            if (cut_at > 0 && k == cut_at) begin
                resetn = 1'b0;
                return;
            end
            if (jitter) begin
                bus.row = 4'($urandom_range(0, 15));
                bus.guess = 12'($urandom);
                bus.erase = 1'($urandom);
                bus.exact_cnt = 3'($urandom);
                bus.partial_cnt = 3'($urandom);
            end
            if (repulse && k == 53) begin
                bus.start = 1'b1; bus.row = 4'd5; bus.exact_cnt = 3'd0;
            end
            if (repulse && k == 54) bus.start = 1'b0;
            // A start held into the DONE cycle must not be taken.
            if (k == ROW_CYC - 1 && jitter) bus.start = 1'b1;
            if (k == ROW_CYC) bus.start = 1'b0;
        end
        check_int({name, " loads"}, loads, 8);
        check_int({name, " draws"}, draws, 128);
        check_int({name, " dones"}, dones, 1);
        @(negedge clk);
        check({name, " idle"}, ROW_CYC + 1, obs(), 24'h0, M_NOXY);
    endtask

    vec_t tbl[4];
    vec_t v;

    initial begin
        tbl[0] = '{row: 4'd0, guess: 12'o7654, erase: 1'b0, ex: 3'd2, pa: 3'd1,
                   x: {8'd55, 8'd50, 8'd45, 8'd40, 8'd26, 8'd20, 8'd14, 8'd8},
                   y: 7'd4,
                   col: {3'd0, 3'd7, 3'd4, 3'd4, 3'd7, 3'd6, 3'd5, 3'd4}};
        tbl[1] = '{row: 4'd9, guess: 12'o7777, erase: 1'b1, ex: 3'd4, pa: 3'd0,
                   x: {8'd55, 8'd50, 8'd45, 8'd40, 8'd26, 8'd20, 8'd14, 8'd8},
                   y: 7'd76,
                   col: '0};
        tbl[2] = '{row: 4'd2, guess: 12'o1234, erase: 1'b0, ex: 3'd3, pa: 3'd4,
                   x: {8'd55, 8'd50, 8'd45, 8'd40, 8'd26, 8'd20, 8'd14, 8'd8},
                   y: 7'd20,
                   col: {3'd7, 3'd4, 3'd4, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4}};
        tbl[3] = '{row: 4'd5, guess: 12'o0000, erase: 1'b0, ex: 3'd7, pa: 3'd5,
                   x: {8'd55, 8'd50, 8'd45, 8'd40, 8'd26, 8'd20, 8'd14, 8'd8},
                   y: 7'd44,
                   col: {3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0}};

        resetn = 1'b0;
        bus.start = 1'b0; bus.erase = 1'b0; bus.row = 4'd0; bus.guess = 12'd0;
        bus.exact_cnt = 3'd0; bus.partial_cnt = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 0, obs(), 24'h0, M_ALL);
        resetn = 1'b1;

        // Hand-computed table
        for (int i = 0; i < 4; i++) run_row($sformatf("tbl%0d", i), tbl[i], 1'b0, 1'b0, 0);

        // Out-of-range row is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.row = 4'd10;
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            if (k == 3) bus.row = 4'd15;
            if (k == 6) bus.start = 1'b0;
            check("badrow", k, obs(), 24'h0, M_NOXY);
        end

        // Second start during peg 3 is dropped
        run_row("repulse", tbl[0], 1'b0, 1'b1, 0);

        // Randomized rows with inputs scrambled while busy
        for (int i = 0; i < 6; i++) begin
            v = model(4'($urandom_range(0, 9)), 12'($urandom), ($urandom_range(0, 3) == 0),
                      3'($urandom), 3'($urandom));
            run_row($sformatf("rnd%0d", i), v, 1'b1, 1'b0, 0);
        end

        // Reset during peg 5 DRAW: one-cycle reset, then nothing, then a clean row
        run_row("cut", tbl[2], 1'b0, 1'b0, 5 * 17 + 6);
        @(negedge clk);
        check("cut reset", 0, obs(), 24'h0, M_ALL);
        resetn = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            check("cut idle", k, obs(), 24'h0, M_ALL);
        end
        run_row("after cut", tbl[3], 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
